// File: rtl/dmask_decode.sv
// dmask_decode
//   Serial decoder for a "low n bits set" mask. A mask accepted in IDLE is
//   scanned one bit per cycle from bit 0 to bit 7. One extra SCAN cycle
//   follows bit 7 to settle the result. The decoded width and an error flag
//   are then presented in DONE until the consumer takes them.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a mask; in_ready=1
//   SCAN  | idx 0..7 examine mask bit idx; idx 8 is a settle cycle
//   DONE  | result valid; held until out_ready=1
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   in_mask holds a mask to decode
//   in_mask    8-bit mask
//   in_ready   block accepts a mask this cycle (IDLE only)
//   out_valid  result valid (DONE only)
//   out_width  count of contiguous ones from bit 0 (0..8)
//   out_err    mask was not of the form low-n-ones with n = 0..7
//   out_ready  consumer takes the result this cycle
//   err_count  saturating count of delivered results with out_err=1
//
// Configuration
//   DMASK_DECODE_ERRCNT_EN  compiles in the err_count register; without it
//                           err_count is tied to 8'h00.

module dmask_decode (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_mask,
    output logic       in_ready,
    output logic       out_valid,
    output logic [4:0] out_width,
    output logic       out_err,
    input  logic       out_ready,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] mask_r;
    logic [3:0] idx;
    logic [3:0] ones;
    logic       seen_zero;
    logic       bad;
    logic       cur_bit;

    assign cur_bit = mask_r[idx[2:0]];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SCAN;
            SCAN:    if (idx == 4'd8) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask_r    <= 8'h00;
            idx       <= 4'd0;
            ones      <= 4'd0;
            seen_zero <= 1'b0;
            bad       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mask_r    <= in_mask;
                        idx       <= 4'd0;
                        ones      <= 4'd0;
                        seen_zero <= 1'b0;
                        bad       <= 1'b0;
                    end
                end
                SCAN: begin
                    // idx 8 examines nothing; it only stretches latency to
                    // a fixed nine cycles between accept and DONE.
                    if (!idx[3]) begin
                        if (cur_bit && !seen_zero) ones <= ones + 4'd1;
                        if (!cur_bit) seen_zero <= 1'b1;
                        if (cur_bit && seen_zero) bad <= 1'b1;
                        idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_width = {1'b0, ones};
    // Eight ones is a width the PROM never produces, so 8'hFF flags an error.
    assign out_err   = bad | (ones == 4'd8);

`ifdef DMASK_DECODE_ERRCNT_EN
    logic [7:0] err_cnt_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= 8'h00;
        end else if ((state == DONE) && out_ready && out_err && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_count = err_cnt_r;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_dmask_decode.sv
module tb_dmask_decode;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_mask;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_width;
    logic       out_err;
    logic       out_ready;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int exp_ec = 0;

    logic [5:0] sb[$];

    dmask_decode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_mask   (in_mask),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_width (out_width),
        .out_err   (out_err),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: width = run of ones from bit 0; error if a one follows a zero
    // or the run covers all eight bits.
    function automatic logic [5:0] model(input logic [7:0] m);
        int  w;
        bit  zero_seen;
        bit  e;
        w = 0;
        zero_seen = 0;
        e = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i] == 1'b0) zero_seen = 1;
            else if (zero_seen) e = 1;
            else w++;
        end
        if (w == 8) e = 1;
        return {e, w[4:0]};
    endfunction

    task automatic accept(input logic [7:0] m);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_mask  = m;
        sb.push_back(model(m));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mask  = 8'($urandom);
    endtask

    task automatic wait_result(output bit ok, output int lat);
        ok  = 0;
        lat = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) ok = 1;
        end
    endtask

    task automatic check_result(input string tag);
        logic [5:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 6'h3F;
        checks++;
        if (out_width !== e[4:0] || out_err !== e[5]) begin
            errors++;
            $display("FAIL %s: width=%h err=%b required width=%h err=%b",
                     tag, out_width, out_err, e[4:0], e[5]);
        end
        if (e[5] && exp_ec < 255) exp_ec++;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b required 1 0",
                     tag, in_ready, out_valid);
        end
`ifdef DMASK_DECODE_ERRCNT_EN
        checks++;
        if (err_count !== 8'(exp_ec)) begin
            errors++;
            $display("FAIL %s_errcnt: err_count=%h required %h", tag, err_count, 8'(exp_ec));
        end
`else
        checks++;
        if (err_count !== 8'h00) begin
            errors++;
            $display("FAIL %s_errcnt: err_count=%h required 00", tag, err_count);
        end
`endif
    endtask

    task automatic decode(input logic [7:0] m, input string tag);
        bit ok;
        int lat;
        accept(m);
        wait_result(ok, lat);
        checks++;
        if (!ok || lat != 9) begin
            errors++;
            $display("FAIL %s_latency: valid=%0d after %0d edges required 9", tag, ok, lat);
            if (!ok) begin
                void'(sb.pop_front());
                return;
            end
        end
        check_result(tag);
        release_result(tag);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_width !== 5'h00 ||
            out_err !== 1'b0 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b w=%h err=%b ec=%h required 1 0 00 0 00",
                     in_ready, out_valid, out_width, out_err, err_count);
        end
    endtask

    task automatic test_basic();
        decode(8'h1F, "basic_1f");
    endtask

    task automatic test_sweep();
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            decode(m, $sformatf("sweep_%0d", i));
            m = {m[6:0], 1'b1};
        end
    endtask

    task automatic test_errors();
        decode(8'h05, "err_05");
        decode(8'hFF, "err_ff");
        decode(8'h80, "err_80");
        decode(8'hFE, "err_fe");
    endtask

    task automatic test_hold();
        bit ok;
        int lat;
        logic [5:0] e;
        accept(8'h07);
        wait_result(ok, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_wait: out_valid=0 required 1");
            void'(sb.pop_front());
            return;
        end
        e = sb[0];
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_mask  = 8'hFF;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_width !== e[4:0] || out_err !== e[5]) begin
                errors++;
                $display("FAIL hold_%0d: vld=%b rdy=%b w=%h err=%b required 1 0 %h %b",
                         c, out_valid, in_ready, out_width, out_err, e[4:0], e[5]);
            end
        end
        in_valid = 1'b0;
        check_result("hold");
        release_result("hold");
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle_%0d: rdy=%b vld=%b required 1 0", c, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        accept(8'h3F);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        void'(sb.pop_front());
        exp_ec = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_width !== 5'h00) begin
            errors++;
            $display("FAIL reset_mid_scan: rdy=%b vld=%b w=%h required 1 0 00",
                     in_ready, out_valid, out_width);
        end
        decode(8'h03, "after_reset");
    endtask

    task automatic test_err_count();
        for (int i = 0; i < 300; i++) decode(8'h80, "errcnt");
        checks++;
`ifdef DMASK_DECODE_ERRCNT_EN
        if (err_count !== 8'hFF) begin
            errors++;
            $display("FAIL errcnt_sat: err_count=%h required FF", err_count);
        end
`else
        if (err_count !== 8'h00) begin
            errors++;
            $display("FAIL errcnt_off: err_count=%h required 00", err_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_errors();
        test_hold();
        test_reset_mid_scan();
        test_err_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
